// File: rtl/mini_sopc_pkg.sv
// Shared constants for the mini_sopc CPU: opcode/funct encodings, ALU operations
// and the default instruction ROM depth.
package mini_sopc_pkg;

  localparam int ROM_WORDS_DEF = 1024;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mini_sopc_if.sv
// Instruction fetch bus between the CPU core (master) and the instruction ROM (slave).
interface mini_sopc_if;
  logic [31:0] pc;
  logic [31:0] inst;

  modport master (output pc, input inst);
  modport slave  (input pc, output inst);
endinterface

// File: rtl/mini_sopc_core.sv
// Single-cycle MIPS-subset core: decoder, ALU, next-PC logic and the register file.
// Unrecognised encodings fall through as NOPs (no write, PC+4).
module mini_sopc_core
  import mini_sopc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  mini_sopc_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] w_inst;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_target;

  logic [31:0] w_rs_data, w_rt_data;
  logic        w_we;
  logic [4:0]  w_waddr;
  alu_op_e     w_alu_op;
  logic        w_use_imm, w_zext;
  logic        w_beq, w_bne, w_jmp;
  logic [31:0] w_imm_ext, w_opb, w_alu_res;
  logic [31:0] w_pc_plus4, w_br_target, w_j_target, w_pc_next;
  logic        w_taken;

  assign bus.pc   = r_pc;
  assign w_inst   = bus.inst;
  assign w_op     = w_inst[31:26];
  assign w_rs     = w_inst[25:21];
  assign w_rt     = w_inst[20:16];
  assign w_rd     = w_inst[15:11];
  assign w_shamt  = w_inst[10:6];
  assign w_funct  = w_inst[5:0];
  assign w_imm    = w_inst[15:0];
  assign w_target = w_inst[25:0];

  mini_sopc_regfile regfile1 (
    .clk       (clk),
    .rst       (rst),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rt_data),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_alu_res)
  );

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = w_rd;
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b0;
    w_zext    = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_jmp     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_we = 1'b1;
        case (w_funct)
          FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:  w_alu_op = ALU_AND;
          FN_OR:   w_alu_op = ALU_OR;
          FN_XOR:  w_alu_op = ALU_XOR;
          FN_NOR:  w_alu_op = ALU_NOR;
          FN_SLT:  w_alu_op = ALU_SLT;
          FN_SLL:  w_alu_op = ALU_SLL;
          FN_SRL:  w_alu_op = ALU_SRL;
          FN_SRA:  w_alu_op = ALU_SRA;
          default: w_we = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        w_we = 1'b1; w_waddr = w_rt; w_use_imm = 1'b1; w_alu_op = ALU_ADD;
      end
      OP_ANDI: begin
        w_we = 1'b1; w_waddr = w_rt; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_AND;
      end
      OP_ORI: begin
        w_we = 1'b1; w_waddr = w_rt; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_OR;
      end
      OP_XORI: begin
        w_we = 1'b1; w_waddr = w_rt; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_XOR;
      end
      OP_LUI: begin
        w_we = 1'b1; w_waddr = w_rt; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_LUI;
      end
      OP_BEQ:  w_beq = 1'b1;
      OP_BNE:  w_bne = 1'b1;
      OP_J:    w_jmp = 1'b1;
      default: ;
    endcase
  end

  assign w_imm_ext = w_zext ? {16'd0, w_imm} : {{16{w_imm[15]}}, w_imm};
  assign w_opb     = w_use_imm ? w_imm_ext : w_rt_data;

  // Shifts operate on rt by shamt; everything else is rs op (rt | imm)
  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_res = w_rs_data + w_opb;
      ALU_SUB: w_alu_res = w_rs_data - w_opb;
      ALU_AND: w_alu_res = w_rs_data & w_opb;
      ALU_OR:  w_alu_res = w_rs_data | w_opb;
      ALU_XOR: w_alu_res = w_rs_data ^ w_opb;
      ALU_NOR: w_alu_res = ~(w_rs_data | w_opb);
      ALU_SLT: w_alu_res = {31'd0, ($signed(w_rs_data) < $signed(w_opb))};
      ALU_SLL: w_alu_res = w_rt_data << w_shamt;
      ALU_SRL: w_alu_res = w_rt_data >> w_shamt;
      ALU_SRA: w_alu_res = $signed(w_rt_data) >>> w_shamt;
      ALU_LUI: w_alu_res = {w_imm, 16'd0};
      default: w_alu_res = '0;
    endcase
  end

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {{14{w_imm[15]}}, w_imm, 2'b00};
  assign w_j_target  = {w_pc_plus4[31:28], w_target, 2'b00};
  assign w_taken     = (w_beq && (w_rs_data == w_rt_data)) ||
                       (w_bne && (w_rs_data != w_rt_data));
  assign w_pc_next   = w_jmp ? w_j_target : (w_taken ? w_br_target : w_pc_plus4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_pc_next;
    end
  end

endmodule

// File: rtl/mini_sopc_regfile.sv
// 32 x 32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module mini_sopc_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] regs [0:31];
  logic [31:0] w_we;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_we
      if (gi == 0) begin : g_zero
        assign w_we[gi] = 1'b0;
      end else begin : g_wr
        assign w_we[gi] = i_we && (i_waddr == 5'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (!rst) begin
        regs[i] <= '0;
      end else if (w_we[i]) begin
        regs[i] <= i_wdata;
      end
    end
  end

  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : regs[i_raddr_b];

endmodule

// File: rtl/mini_sopc_rom.sv
// Word-addressed instruction ROM with combinational read; contents are preloaded
// hierarchically into inst_mem by the simulation environment.
module mini_sopc_rom
  import mini_sopc_pkg::*;
#(
  parameter int ROM_WORDS = ROM_WORDS_DEF
) (
  mini_sopc_if.slave bus
);

  localparam int AW = $clog2(ROM_WORDS);

  logic [31:0]   inst_mem [0:ROM_WORDS-1];
  logic [AW-1:0] w_idx;
  logic          w_unused_pc;

  // Byte address to word index; upper bits drop out so fetches wrap modulo ROM size
  assign w_idx       = bus.pc[AW+1:2];
  assign w_unused_pc = ^{bus.pc[31:AW+2], bus.pc[1:0]};
  assign bus.inst    = inst_mem[w_idx];

endmodule

// File: rtl/mini_sopc.sv
// CPU bring-up top level: the core (top0) fetching from the instruction ROM (inst_rom0).
module mini_sopc
  import mini_sopc_pkg::*;
#(
  parameter int ROM_WORDS = ROM_WORDS_DEF
) (
  input logic clk,
  input logic rst
);

  mini_sopc_if w_fetch_bus ();

  mini_sopc_core top0 (
    .clk (clk),
    .rst (rst),
    .bus (w_fetch_bus.master)
  );

  mini_sopc_rom #(
    .ROM_WORDS (ROM_WORDS)
  ) inst_rom0 (
    .bus (w_fetch_bus.slave)
  );

endmodule

// File: tb/tb_mini_sopc.sv
// Directed bench for mini_sopc: hand-written program sequences plus a table of
// single-instruction vectors with hand-computed register and PC results.
module tb_mini_sopc;
  import mini_sopc_pkg::*;

  localparam int ROM_WORDS = 1024;

  typedef struct {
    int          word;
    logic [31:0] inst;
    int          chk_reg;
    logic [31:0] exp_val;
    logic [31:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] exp_regs [32];
  vec_t        vecs [19];

  always #5 clk = ~clk;

  mini_sopc #(.ROM_WORDS(ROM_WORDS)) dut (
    .clk (clk),
    .rst (rst)
  );

  mini_sopc_if mon ();
  assign mon.pc   = dut.top0.r_pc;
  assign mon.inst = dut.top0.w_inst;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < ROM_WORDS; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s r%0d", tag, i), dut.top0.regfile1.regs[i], exp_regs[i]);
  endtask

  task automatic load_prog1();
    dut.inst_rom0.inst_mem[0] = 32'h34011100;
    dut.inst_rom0.inst_mem[1] = 32'h34020020;
    dut.inst_rom0.inst_mem[2] = 32'h3403FF00;
    dut.inst_rom0.inst_mem[3] = 32'h3C041234;
    dut.inst_rom0.inst_mem[4] = 32'h00232825;
    dut.inst_rom0.inst_mem[5] = 32'h00223021;
    dut.inst_rom0.inst_mem[6] = 32'h34000005;
    dut.inst_rom0.inst_mem[7] = 32'h00003821;
    dut.inst_rom0.inst_mem[8] = 32'h1000FFFF;
  endtask

  task automatic run_prog1(input string tag);
    rst = 1'b1;
    repeat (4) step();
    check({tag, " ori r1"}, dut.top0.regfile1.regs[1], 32'h00001100);
    check({tag, " ori r2"}, dut.top0.regfile1.regs[2], 32'h00000020);
    check({tag, " ori r3"}, dut.top0.regfile1.regs[3], 32'h0000FF00);
    check({tag, " lui r4"}, dut.top0.regfile1.regs[4], 32'h12340000);
    step();
    check({tag, " or r5"}, dut.top0.regfile1.regs[5], 32'h0000FF00);
    step();
    check({tag, " addu r6"}, dut.top0.regfile1.regs[6], 32'h00001120);
    $display("%s: 6 instructions executed, pc=%08h", tag, mon.pc);
  endtask

  initial begin
    vecs[0]  = '{0,  32'h34018000, 1,  32'h00008000, 32'h04};
    vecs[1]  = '{1,  32'h00014400, 8,  32'h80000000, 32'h08};
    vecs[2]  = '{2,  32'h00084C03, 9,  32'hFFFF8000, 32'h0C};
    vecs[3]  = '{3,  32'h0120502A, 10, 32'h00000001, 32'h10};
    vecs[4]  = '{4,  32'h2402FFFF, 2,  32'hFFFFFFFF, 32'h14};
    vecs[5]  = '{5,  32'h00221823, 3,  32'h00008001, 32'h18};
    vecs[6]  = '{6,  32'h00202027, 4,  32'hFFFF7FFF, 32'h1C};
    vecs[7]  = '{7,  32'h00022F02, 5,  32'h0000000F, 32'h20};
    vecs[8]  = '{8,  32'h38A600F0, 6,  32'h000000FF, 32'h24};
    vecs[9]  = '{9,  32'h14A00002, 5,  32'h0000000F, 32'h30};
    vecs[10] = '{12, 32'h10220005, 1,  32'h00008000, 32'h34};
    vecs[11] = '{13, 32'h30877FF0, 7,  32'h00007FF0, 32'h38};
    vecs[12] = '{14, 32'h08000010, 7,  32'h00007FF0, 32'h40};
    vecs[13] = '{16, 32'h0143582A, 11, 32'h00000001, 32'h44};
    vecs[14] = '{17, 32'h00666024, 12, 32'h00000001, 32'h48};
    vecs[15] = '{18, 32'h00226826, 13, 32'hFFFF7FFF, 32'h4C};
    vecs[16] = '{19, 32'h7C0A0001, 10, 32'h00000001, 32'h50};
    vecs[17] = '{20, 32'h1000FFFF, 13, 32'hFFFF7FFF, 32'h50};
    vecs[18] = '{20, 32'h1000FFFF, 14, 32'h00000000, 32'h50};

    // Reset state
    rst = 1'b0;
    clear_rom();
    step();
    step();
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'h0;
    check("reset pc", mon.pc, 32'h0);
    check_all_regs("reset");

    // Immediates, R-type with read-after-write
    load_prog1();
    run_prog1("prog1");

    // Reset mid-run aborts the pending ori $0 and clears everything
    rst = 1'b0;
    step();
    step();
    check("midrst pc", mon.pc, 32'h0);
    check_all_regs("midrst");

    // Re-execution from address 0, then the $0 immutability pair
    run_prog1("rerun");
    step();
    step();
    check("r0 after ori $0", dut.top0.regfile1.regs[0], 32'h0);
    check("addu r7 from $0", dut.top0.regfile1.regs[7], 32'h0);
    check("prog1 loop pc", mon.pc, 32'h20);

    // Branch-to-self at 0x10 holds PC and registers for 100 cycles
    rst = 1'b0;
    clear_rom();
    dut.inst_rom0.inst_mem[0] = 32'h34011100;
    dut.inst_rom0.inst_mem[1] = 32'h34020020;
    dut.inst_rom0.inst_mem[2] = 32'h3403FF00;
    dut.inst_rom0.inst_mem[3] = 32'h3C041234;
    dut.inst_rom0.inst_mem[4] = 32'h1000FFFF;
    step();
    step();
    rst = 1'b1;
    repeat (4) step();
    check("loop entry pc", mon.pc, 32'h10);
    for (int c = 0; c < 100; c++) begin
      step();
      check($sformatf("loop pc c%0d", c), mon.pc, 32'h10);
    end
    exp_regs[1] = 32'h00001100;
    exp_regs[2] = 32'h00000020;
    exp_regs[3] = 32'h0000FF00;
    exp_regs[4] = 32'h12340000;
    check_all_regs("loop");
    $display("loop: 100 cycles held at pc=%08h inst=%08h", mon.pc, mon.inst);

    // Table-driven single-instruction vectors (shifts, slt, branches, jump, NOP)
    rst = 1'b0;
    clear_rom();
    for (int v = 0; v < 19; v++) dut.inst_rom0.inst_mem[vecs[v].word] = vecs[v].inst;
    dut.inst_rom0.inst_mem[10] = 32'h340E0BAD;
    dut.inst_rom0.inst_mem[11] = 32'h340E0BAD;
    dut.inst_rom0.inst_mem[15] = 32'h340E0BAD;
    step();
    step();
    rst = 1'b1;
    for (int v = 0; v < 19; v++) begin
      check($sformatf("vec%0d fetch", v), mon.inst, vecs[v].inst);
      step();
      $display("vec %0d: inst=%08h r%0d=%08h pc=%08h", v, vecs[v].inst, vecs[v].chk_reg,
               dut.top0.regfile1.regs[vecs[v].chk_reg], mon.pc);
      check($sformatf("vec%0d r%0d", v, vecs[v].chk_reg),
            dut.top0.regfile1.regs[vecs[v].chk_reg], vecs[v].exp_val);
      check($sformatf("vec%0d pc", v), mon.pc, vecs[v].exp_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
